// File: rtl/nested_struct_assembler.sv
// Packs a checksummed 9-byte stream frame into the 62-bit nested struct
// word, with one-entry output buffering and error accounting.
module nested_struct_assembler #(
    parameter int FRAME_CNT_W = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_byte,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [61:0]            out_data,
    output logic                   err_chk,
    output logic                   err_len,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    typedef enum logic {COLLECT, DRAIN} state_t;

    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = 1;
    localparam logic [ERR_CNT_W-1:0]   ERR_ONE   = 1;

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [7:0]  csum, csum_next;
    logic [7:0]  bytes_q [8];
    logic        accept;
    logic        store;
    logic        load;
    logic        chk_fire;
    logic        len_fire;
    logic [61:0] frame_word;
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= 4'd0;
            csum      <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            csum    <= csum_next;
            err_chk <= chk_fire;
            err_len <= len_fire;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= frame_word;
                frame_cnt <= frame_cnt + FRAME_ONE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if ((chk_fire || len_fire) && err_cnt != '1)
                err_cnt <= err_cnt + ERR_ONE;
        end
    end

    // Payload bytes need no reset: they only reach out_data through a load.
    always_ff @(posedge clk) begin
        if (store)
            bytes_q[idx[2:0]] <= in_byte;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        csum_next  = csum;
        store      = 1'b0;
        load       = 1'b0;
        chk_fire   = 1'b0;
        len_fire   = 1'b0;
        if (accept) begin
            unique case (state)
                COLLECT: begin
                    if (idx != 4'd8) begin
                        if (in_last) begin
                            len_fire  = 1'b1;
                            idx_next  = 4'd0;
                            csum_next = 8'd0;
                        end else begin
                            store     = 1'b1;
                            idx_next  = idx + 4'd1;
                            csum_next = csum ^ in_byte;
                        end
                    end else begin
                        idx_next  = 4'd0;
                        csum_next = 8'd0;
                        if (!in_last) begin
                            len_fire   = 1'b1;
                            state_next = DRAIN;
                        end else if (in_byte == csum) begin
                            load = 1'b1;
                        end else begin
                            chk_fire = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (in_last)
                        state_next = COLLECT;
                end
            endcase
        end
    end

    // Stall only when the checksum byte would need a full output register.
    always_comb begin
        in_ready = !(state == COLLECT && idx == 4'd8 &&
                     out_valid && !out_ready);
        accept = in_valid && in_ready;
        frame_word = {bytes_q[0],
                      bytes_q[1], bytes_q[2], bytes_q[3], bytes_q[4],
                      bytes_q[7][7],
                      bytes_q[5], bytes_q[6],
                      bytes_q[7][6:3],
                      bytes_q[7][2]};
        unused_bits = ^bytes_q[7][1:0];
    end

endmodule

// File: tb/tb_nested_struct_assembler.sv
// Randomized scoreboard bench for nested_struct_assembler.
// Expected words are queued at issue time and popped by a monitor.
module tb_nested_struct_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [61:0] out_data;
    logic        err_chk;
    logic        err_len;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    nested_struct_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_chk   (err_chk),
        .err_len   (err_len),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [61:0] sb[$];
    int          exp_frames = 0;
    int          exp_err = 0;
    int          exp_chk = 0;
    int          exp_len = 0;
    int          got_chk = 0;
    int          got_len = 0;
    bit          rnd_ready = 0;
    bit          gaps = 0;
    bit          held_v = 0;
    logic [61:0] held;
    logic [7:0]  fr [16];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [61:0] model();
        return {fr[0], fr[1], fr[2], fr[3], fr[4], fr[7][7],
                fr[5], fr[6], fr[7][6:3], fr[7][2]};
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Monitor: output scoreboard, hold stability, error pulse tally.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 0;
        end else begin
            if (err_chk || err_len)
                check("err_exclusive", {63'd0, err_chk & err_len}, 64'd0);
            if (err_chk) got_chk++;
            if (err_len) got_len++;
            if (held_v && out_valid) check("hold_stable", out_data, held);
            held_v = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic l);
        int  n;
        bit  ok;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                $display("FAIL accept_timeout: in_ready stuck at 0");
                $fatal(1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    endtask

    task automatic tx(input int n, input bit last_on_end);
        for (int i = 0; i < n; i++)
            drive(fr[i], last_on_end && (i == n - 1));
    endtask

    task automatic fill_random();
        fr[8] = 8'd0;
        for (int i = 0; i < 8; i++) begin
            fr[i] = 8'($urandom);
            fr[8] = fr[8] ^ fr[i];
        end
        for (int i = 9; i < 16; i++) fr[i] = 8'($urandom);
    endtask

    task automatic send_good();
        sb.push_back(model());
        exp_frames++;
        tx(9, 1);
    endtask

    task automatic send_badchk(input logic [7:0] flip);
        fr[8] = fr[8] ^ flip;
        exp_chk++;
        exp_err++;
        tx(9, 1);
        fr[8] = fr[8] ^ flip;
    endtask

    task automatic send_short(input int n);
        exp_len++;
        exp_err++;
        tx(n, 1);
    endtask

    task automatic send_long(input int extra);
        exp_len++;
        exp_err++;
        tx(9 + extra, 1);
    endtask

    task automatic reset_checks();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {2'd0, out_data}, 64'd0);
        check("rst_err_chk", {63'd0, err_chk}, 64'd0);
        check("rst_err_len", {63'd0, err_len}, 64'd0);
        check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic counter_checks(input string tag);
        check({tag, "_frame_cnt"}, {48'd0, frame_cnt}, 64'(exp_frames % 65536));
        check({tag, "_err_cnt"}, {56'd0, err_cnt}, 64'(sat(exp_err)));
        check({tag, "_chk_pulses"}, 64'(got_chk), 64'(exp_chk));
        check({tag, "_len_pulses"}, 64'(got_len), 64'(exp_len));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'd0;
        in_last = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;

        // Reference frame with hand-decoded fields.
        fr[0] = 8'h12; fr[1] = 8'hDE; fr[2] = 8'hAD; fr[3] = 8'hBE;
        fr[4] = 8'hEF; fr[5] = 8'h00; fr[6] = 8'h64; fr[7] = 8'hD4;
        fr[8] = 8'h12 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h00 ^ 8'h64 ^ 8'hD4;
        sb.push_back({8'h12, 32'hDEADBEEF, 1'b1, 16'h0064, 4'hA, 1'b1});
        exp_frames++;
        tx(9, 1);
        idle(3);
        counter_checks("good");

        send_badchk(8'h01);
        @(negedge clk);
        check("badchk_no_valid", {63'd0, out_valid}, 64'd0);
        idle(2);
        counter_checks("badchk");
        send_good();
        idle(2);

        fill_random();
        send_short(5);
        send_good();
        send_long(3);
        send_good();
        idle(3);
        counter_checks("len");

        // Backpressure: second checksum byte must stall until a consume.
        out_ready = 1'b0;
        fill_random();
        send_good();
        fill_random();
        sb.push_back(model());
        exp_frames++;
        tx(8, 0);
        in_valid = 1'b1;
        in_byte = fr[8];
        in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        check("bp_back_to_back", {63'd0, out_valid}, 64'd1);
        idle(3);
        counter_checks("bp");

        // Reset with a held output and a partial frame in flight.
        out_ready = 1'b0;
        fill_random();
        send_good();
        fill_random();
        tx(6, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sb.delete();
        exp_frames = 0; exp_err = 0; exp_chk = 0; exp_len = 0;
        got_chk = 0; got_len = 0;
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fill_random();
        send_good();
        idle(3);
        counter_checks("post_rst");

        // Randomized mix of frame kinds, gaps and backpressure.
        gaps = 1;
        rnd_ready = 1;
        for (int k = 0; k < 60; k++) begin
            fill_random();
            case ($urandom_range(0, 5))
                0: send_badchk(8'($urandom_range(1, 255)));
                1: send_short($urandom_range(1, 8));
                2: send_long($urandom_range(1, 4));
                default: send_good();
            endcase
        end
        rnd_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        gaps = 0;
        idle(20);
        counter_checks("random");
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Error counter saturation.
        fill_random();
        for (int k = 0; k < 300; k++) send_badchk(8'h80);
        idle(3);
        counter_checks("saturate");
        check("saturate_255", {56'd0, err_cnt}, 64'd255);
        fill_random();
        send_good();
        idle(3);
        counter_checks("final");
        check("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
